// File: rtl/cs_trgt_chan_ctrl_if.sv
// ---------------------------------------------------------------------------
// cs_trgt_chan_ctrl_if
// Transport-side bundle of the target channel controller.
//   get_req_o / get_ch_o / get_rdy_i : fetch request for one channel
//   rsp_valid_i / rsp_data_i         : one-cycle fetch response
//   put_req_o / put_data_o / put_rdy_i : upload request
// The _i/_o suffixes are seen from the controller, which uses the master
// modport; the transport model or bench uses the slave modport.
//
// Handshake rule, shared by get and put: a request is raised and held, along
// with its payload or channel index, until the transport samples ready high on
// a rising clk_i edge. That edge is the transfer. Ready may arrive at any
// time, and ready sampled while no request is raised means nothing. The
// response is not a handshake: rsp_valid_i is a one-cycle pulse with no
// back-pressure.
// ---------------------------------------------------------------------------
interface cs_trgt_chan_ctrl_if #(
    parameter int DW = 9,
    parameter int CW = 2
);
    logic          get_req_o;
    logic [CW-1:0] get_ch_o;
    logic          get_rdy_i;
    logic          rsp_valid_i;
    logic [DW-1:0] rsp_data_i;
    logic          put_req_o;
    logic [DW-1:0] put_data_o;
    logic          put_rdy_i;

    modport master (
        output get_req_o, get_ch_o, put_req_o, put_data_o,
        input  get_rdy_i, rsp_valid_i, rsp_data_i, put_rdy_i
    );

    modport slave (
        input  get_req_o, get_ch_o, put_req_o, put_data_o,
        output get_rdy_i, rsp_valid_i, rsp_data_i, put_rdy_i
    );
endinterface

// File: rtl/cs_trgt_chan_ctrl.sv
// ---------------------------------------------------------------------------
// cs_trgt_chan_ctrl
// Freezes each mission-clock channel on its edge event, fetches the next
// download payload for it over the transport, and releases the channel when
// the payload arrives. Fetches are serialised by a round-robin arbiter. A
// watchdog marks a channel as failed if its response never comes. A separate
// one-deep upload path forwards put events to the transport.
//
// Ports
//   clk_i, rst_i   clock and synchronous active-high reset
//   ev_i           per-channel edge event, one-cycle pulse
//   freeze_o       per-channel hold: a fetch is pending, or the channel failed
//   rd_data_o      per-channel payload; channel c occupies [c*DW +: DW]
//   rd_valid_o     one-cycle pulse when a channel slice is updated
//   put_ev_i       upload event
//   up_data_i      upload payload
//   timeout_o      sticky watchdog expiry
//   fail_o         sticky per-channel failure
//   ovf_o          sticky overrun: event on a pending channel, or put overrun
//   dbg_state_o    fetch FSM state (0 idle, 1 request, 2 wait)
//   tp             transport bundle (master side)
// ---------------------------------------------------------------------------
module cs_trgt_chan_ctrl #(
    parameter int NCH    = 3,
    parameter int DW     = 9,
    parameter int WD_MAX = 100,
    parameter int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NCH-1:0]      ev_i,
    output logic [NCH-1:0]      freeze_o,
    output logic [NCH*DW-1:0]   rd_data_o,
    output logic [NCH-1:0]      rd_valid_o,
    input  logic                put_ev_i,
    input  logic [DW-1:0]       up_data_i,
    output logic                timeout_o,
    output logic [NCH-1:0]      fail_o,
    output logic                ovf_o,
    output logic [1:0]          dbg_state_o,
    cs_trgt_chan_ctrl_if.master tp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam int             WDW     = $clog2(WD_MAX + 1);
    // The counter starts at 0 on the first cycle in WAIT. Expiry therefore
    // happens on the WD_MAX-th cycle spent waiting.
    localparam logic [WDW-1:0] WD_LAST = WDW'(WD_MAX - 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       cur_q, last_q, sel;
    logic                sel_ok;
    logic [WDW-1:0]      wd_q;
    logic [NCH-1:0]      pending_q, fail_q, rd_valid_q;
    logic [NCH*DW-1:0]   rd_data_q;
    logic                timeout_q, ovf_q, put_req_q;
    logic [DW-1:0]       put_data_q;
    logic                rsp_hit, expire;

    function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] base, input int off);
        int j;
        j = int'(base) + off;
        if (j >= NCH) j = j - NCH;
        return CW'(j);
    endfunction

    // Round-robin: scan from the channel after the last one served.
    // The last step of the scan wraps back to the last-served channel itself.
    always_comb begin
        sel    = last_q;
        sel_ok = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            if (!sel_ok && pending_q[wrap_add(last_q, i)]) begin
                sel    = wrap_add(last_q, i);
                sel_ok = 1'b1;
            end
        end
    end

    // A response in the expiry cycle still counts as a response.
    assign rsp_hit = (state_q == S_WAIT) && tp.rsp_valid_i;
    assign expire  = (state_q == S_WAIT) && !tp.rsp_valid_i && (wd_q == WD_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sel_ok) state_d = S_REQ;
            S_REQ:   if (tp.get_rdy_i) state_d = S_WAIT;
            S_WAIT:  if (rsp_hit || expire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_q      <= '0;
            last_q     <= CW'(NCH - 1);   // channel 0 is the first winner
            wd_q       <= '0;
            pending_q  <= '0;
            fail_q     <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            timeout_q  <= 1'b0;
            ovf_q      <= 1'b0;
            put_req_q  <= 1'b0;
            put_data_q <= '0;
        end else begin
            rd_valid_q <= '0;

            if (state_q == S_IDLE && sel_ok) begin
                cur_q  <= sel;
                last_q <= sel;
            end

            if (state_q == S_REQ && tp.get_rdy_i)
                wd_q <= '0;
            else if (state_q == S_WAIT && wd_q != WD_LAST)
                wd_q <= wd_q + 1'b1;

            for (int c = 0; c < NCH; c++) begin
                if (expire && cur_q == CW'(c)) begin
                    // Failure wins over any event in the same cycle. The
                    // freeze is held afterwards through fail_q.
                    pending_q[c] <= 1'b0;
                    fail_q[c]    <= 1'b1;
                    timeout_q    <= 1'b1;
                end else if (ev_i[c] && !fail_q[c]) begin
                    // An event on the completion cycle re-arms the channel.
                    if (pending_q[c] && !(rsp_hit && cur_q == CW'(c)))
                        ovf_q <= 1'b1;
                    else
                        pending_q[c] <= 1'b1;
                end else if (rsp_hit && cur_q == CW'(c)) begin
                    pending_q[c] <= 1'b0;
                end

                if (rsp_hit && cur_q == CW'(c)) begin
                    rd_data_q[c*DW +: DW] <= tp.rsp_data_i;
                    rd_valid_q[c]         <= 1'b1;
                end
            end

            // One-deep upload slot. It can be refilled in the cycle it is
            // accepted.
            if (put_ev_i && (!put_req_q || tp.put_rdy_i)) begin
                put_data_q <= up_data_i;
                put_req_q  <= 1'b1;
            end else if (put_ev_i) begin
                ovf_q <= 1'b1;
            end else if (tp.put_rdy_i) begin
                put_req_q <= 1'b0;
            end
        end
    end

    assign freeze_o      = pending_q | fail_q;
    assign rd_data_o     = rd_data_q;
    assign rd_valid_o    = rd_valid_q;
    assign timeout_o     = timeout_q;
    assign fail_o        = fail_q;
    assign ovf_o         = ovf_q;
    assign dbg_state_o   = state_q;
    assign tp.get_req_o  = (state_q == S_REQ);
    assign tp.get_ch_o   = cur_q;
    assign tp.put_req_o  = put_req_q;
    assign tp.put_data_o = put_data_q;

endmodule

// File: tb/tb_cs_trgt_chan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cs_trgt_chan_ctrl
// Scenario tasks drive the controller and its transport. Outputs are compared
// against expectations built from the channel rules: round-robin service
// order, payload slices, watchdog length, and the one-slot upload buffer.
// Inputs change, and outputs are sampled, 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_cs_trgt_chan_ctrl;
    localparam int NCH = 3, DW = 9, WD_MAX = 100, CW = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NCH-1:0]    ev_i, freeze_o, rd_valid_o, fail_o;
    logic [NCH*DW-1:0] rd_data_o;
    logic              put_ev_i, timeout_o, ovf_o;
    logic [DW-1:0]     up_data_i;
    logic [1:0]        dbg_state_o;

    int checks   = 0;
    int failures = 0;
    logic [CW-1:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    cs_trgt_chan_ctrl_if #(.DW(DW), .CW(CW)) tp();

    cs_trgt_chan_ctrl #(.NCH(NCH), .DW(DW), .WD_MAX(WD_MAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ev_i(ev_i), .freeze_o(freeze_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .put_ev_i(put_ev_i),
        .up_data_i(up_data_i), .timeout_o(timeout_o), .fail_o(fail_o),
        .ovf_o(ovf_o), .dbg_state_o(dbg_state_o), .tp(tp)
    );

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        ev_i = '0; put_ev_i = 1'b0; up_data_i = '0;
        tp.get_rdy_i = 1'b0; tp.rsp_valid_i = 1'b0; tp.rsp_data_i = '0; tp.put_rdy_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
    endtask

    task automatic pulse_ev(input logic [NCH-1:0] m);
        ev_i = m;
        tick();
        ev_i = '0;
    endtask

    // Plays the transport for one fetch. Returns the requested channel and the
    // number of edges from entry to the response edge.
    task automatic serve_fetch(input int rdy_dly, input int rsp_dly, input logic [DW-1:0] data,
                               input logic [NCH-1:0] ev_at_rsp, output int ch, output int cycles,
                               output bit ok);
        int n = 0;
        ok = 1'b1; ch = -1; cycles = 0;
        while (!tp.get_req_o && n < 20) begin tick(); n++; end
        if (!tp.get_req_o) begin ok = 1'b0; cycles = n; return; end
        ch = int'(tp.get_ch_o);
        repeat (rdy_dly) begin tick(); n++; end
        tp.get_rdy_i = 1'b1; tick(); n++; tp.get_rdy_i = 1'b0;
        repeat (rsp_dly) begin tick(); n++; end
        tp.rsp_valid_i = 1'b1; tp.rsp_data_i = data; ev_i = ev_at_rsp;
        tick(); n++;
        tp.rsp_valid_i = 1'b0; ev_i = '0;
        cycles = n;
    endtask

    // Reference arbitration: the first pending channel after the last one
    // served, scanning upward with wrap-around.
    function automatic int rr_pick(input logic [NCH-1:0] p, input int last);
        for (int i = 1; i <= NCH; i++) begin
            int j = (last + i) % NCH;
            if (p[j]) return j;
        end
        return -1;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        ev_i = 3'b111; put_ev_i = 1'b1; up_data_i = 9'h1FF;
        tick(); tick();
        checks++; if (freeze_o !== 3'b000 || fail_o !== 3'b000)
            begin failures++; $display("FAIL reset_freeze_fail: got %b/%b expected 000/000", freeze_o, fail_o); end
        checks++; if (rd_data_o !== '0 || rd_valid_o !== 3'b000)
            begin failures++; $display("FAIL reset_rd: got %h/%b expected 0/000", rd_data_o, rd_valid_o); end
        checks++; if (tp.get_req_o !== 1'b0 || tp.get_ch_o !== 2'd0 || dbg_state_o !== 2'd0)
            begin failures++; $display("FAIL reset_get: got %b/%0d/%0d expected 0/0/0", tp.get_req_o, tp.get_ch_o, dbg_state_o); end
        checks++; if (tp.put_req_o !== 1'b0 || tp.put_data_o !== 9'h000)
            begin failures++; $display("FAIL reset_put: got %b/%h expected 0/000", tp.put_req_o, tp.put_data_o); end
        checks++; if (timeout_o !== 1'b0 || ovf_o !== 1'b0)
            begin failures++; $display("FAIL reset_flags: got %b/%b expected 0/0", timeout_o, ovf_o); end
        idle_inputs();
        rst_i = 1'b0;
    endtask

    task automatic test_single_fetch();
        int ch, cyc; bit ok;
        logic [NCH*DW-1:0] exp_rd;
        logic [DW-1:0] d;
        do_reset();
        tp.rsp_valid_i = 1'b1; tp.rsp_data_i = 9'h0FF; tick(); tp.rsp_valid_i = 1'b0;
        checks++; if (rd_valid_o !== 3'b000 || rd_data_o !== '0)
            begin failures++; $display("FAIL rsp_in_idle: got %b/%h expected 000/0", rd_valid_o, rd_data_o); end
        pulse_ev(3'b001);
        checks++; if (freeze_o !== 3'b001)
            begin failures++; $display("FAIL single_freeze_set: got %b expected 001", freeze_o); end
        serve_fetch(0, 1, 9'h1A5, '0, ch, cyc, ok);
        exp_rd = '0; exp_rd[0 +: DW] = 9'h1A5;
        checks++; if (!ok || ch != 0)
            begin failures++; $display("FAIL single_ch: got %0d ok=%0d expected 0", ch, ok); end
        checks++; if (rd_valid_o !== 3'b001 || rd_data_o !== exp_rd || freeze_o !== 3'b000)
            begin failures++; $display("FAIL single_done: got %b/%h/%b expected 001/%h/000", rd_valid_o, rd_data_o, freeze_o, exp_rd); end
        tick();
        checks++; if (rd_valid_o !== 3'b000)
            begin failures++; $display("FAIL single_pulse: got %b expected 000", rd_valid_o); end
        d = 9'($urandom_range(0, 511));
        pulse_ev(3'b001);
        serve_fetch(0, 0, d, '0, ch, cyc, ok);
        checks++; if (!ok || cyc + 1 != 4 || freeze_o !== 3'b000)
            begin failures++; $display("FAIL min_latency: got %0d cycles freeze=%b expected 4/000", cyc + 1, freeze_o); end
    endtask

    task automatic test_round_robin();
        int ch, cyc, last, pick; bit ok;
        logic [NCH-1:0] mask, p;
        logic [NCH*DW-1:0] exp_rd;
        logic [DW-1:0] d;
        logic [CW-1:0] e;
        do_reset();
        last = NCH - 1; exp_rd = '0;
        for (int it = 0; it < 12; it++) begin
            mask = (it == 0) ? 3'b111 : (it == 1) ? 3'b011 : 3'($urandom_range(1, 7));
            pulse_ev(mask);
            p = mask;
            while (p != 0) begin
                pick = rr_pick(p, last);
                exp_q.push_back(CW'(pick));
                p[pick] = 1'b0;
                last = pick;
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                d = 9'($urandom_range(0, 511));
                serve_fetch($urandom_range(0, 3), $urandom_range(0, 5), d, '0, ch, cyc, ok);
                exp_rd[int'(e)*DW +: DW] = d;
                checks++; if (!ok || ch != int'(e))
                    begin failures++; $display("FAIL rr_order it%0d: got %0d expected %0d", it, ch, e); end
                checks++; if (rd_valid_o !== (3'b001 << e) || rd_data_o !== exp_rd)
                    begin failures++; $display("FAIL rr_data it%0d: got %b/%h expected %b/%h", it, rd_valid_o, rd_data_o, 3'b001 << e, exp_rd); end
            end
            checks++; if (freeze_o !== 3'b000)
                begin failures++; $display("FAIL rr_release it%0d: got %b expected 000", it, freeze_o); end
        end
    endtask

    task automatic test_watchdog();
        int n, ch, cyc; bit ok, saw_req;
        do_reset();
        pulse_ev(3'b010);
        n = 0;
        while (!tp.get_req_o && n < 20) begin tick(); n++; end
        checks++; if (tp.get_req_o !== 1'b1 || tp.get_ch_o !== 2'd1)
            begin failures++; $display("FAIL wd_req: got %b/%0d expected 1/1", tp.get_req_o, tp.get_ch_o); end
        tp.get_rdy_i = 1'b1; tick(); tp.get_rdy_i = 1'b0;
        n = 0;
        while (!timeout_o && n < WD_MAX + 10) begin tick(); n++; end
        checks++; if (n != WD_MAX || timeout_o !== 1'b1)
            begin failures++; $display("FAIL wd_expiry: got %0d cycles timeout=%b expected %0d/1", n, timeout_o, WD_MAX); end
        checks++; if (fail_o !== 3'b010 || freeze_o !== 3'b010 || tp.get_req_o !== 1'b0 || rd_valid_o !== 3'b000)
            begin failures++; $display("FAIL wd_state: got fail=%b freeze=%b req=%b rdv=%b expected 010/010/0/000", fail_o, freeze_o, tp.get_req_o, rd_valid_o); end
        pulse_ev(3'b010);
        saw_req = 1'b0;
        repeat (4) begin saw_req |= tp.get_req_o; tick(); end
        checks++; if (saw_req || freeze_o !== 3'b010 || ovf_o !== 1'b0)
            begin failures++; $display("FAIL wd_ignore_ev: got req=%b freeze=%b ovf=%b expected 0/010/0", saw_req, freeze_o, ovf_o); end
        pulse_ev(3'b001);
        serve_fetch(1, 2, 9'h03C, '0, ch, cyc, ok);
        checks++; if (!ok || ch != 0 || freeze_o !== 3'b010 || fail_o !== 3'b010)
            begin failures++; $display("FAIL wd_other_ch: got ch=%0d freeze=%b fail=%b expected 0/010/010", ch, freeze_o, fail_o); end
    endtask

    task automatic test_overrun();
        int ch, cyc, n; bit ok, saw_req;
        do_reset();
        pulse_ev(3'b100);
        checks++; if (ovf_o !== 1'b0)
            begin failures++; $display("FAIL ovf_first_ev: got %b expected 0", ovf_o); end
        pulse_ev(3'b100);
        checks++; if (ovf_o !== 1'b1)
            begin failures++; $display("FAIL ovf_second_ev: got %b expected 1", ovf_o); end
        serve_fetch(0, 1, 9'h111, '0, ch, cyc, ok);
        checks++; if (!ok || ch != 2 || rd_valid_o !== 3'b100)
            begin failures++; $display("FAIL ovf_fetch: got ch=%0d rdv=%b expected 2/100", ch, rd_valid_o); end
        saw_req = 1'b0;
        for (n = 0; n < 6; n++) begin saw_req |= tp.get_req_o; tick(); end
        checks++; if (saw_req || freeze_o !== 3'b000)
            begin failures++; $display("FAIL ovf_single_fetch: got req=%b freeze=%b expected 0/000", saw_req, freeze_o); end
        do_reset();
        pulse_ev(3'b100);
        serve_fetch(0, 0, 9'h0A0, 3'b100, ch, cyc, ok);
        checks++; if (!ok || rd_valid_o !== 3'b100 || freeze_o !== 3'b100 || ovf_o !== 1'b0)
            begin failures++; $display("FAIL ev_on_done: got rdv=%b freeze=%b ovf=%b expected 100/100/0", rd_valid_o, freeze_o, ovf_o); end
        serve_fetch(0, 0, 9'h0B0, '0, ch, cyc, ok);
        checks++; if (!ok || ch != 2 || rd_data_o[2*DW +: DW] !== 9'h0B0 || freeze_o !== 3'b000)
            begin failures++; $display("FAIL ev_on_done_refetch: got ch=%0d data=%h freeze=%b expected 2/0b0/000", ch, rd_data_o[2*DW +: DW], freeze_o); end
    endtask

    task automatic test_put();
        logic [DW-1:0] slot_q[$];
        logic [DW-1:0] d;
        logic m_ovf;
        bit pev, prdy;
        do_reset();
        up_data_i = 9'h155; put_ev_i = 1'b1; tick(); put_ev_i = 1'b0;
        checks++; if (tp.put_req_o !== 1'b1 || tp.put_data_o !== 9'h155)
            begin failures++; $display("FAIL put_load: got %b/%h expected 1/155", tp.put_req_o, tp.put_data_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (tp.put_req_o !== 1'b1 || tp.put_data_o !== 9'h155)
                begin failures++; $display("FAIL put_hold%0d: got %b/%h expected 1/155", i, tp.put_req_o, tp.put_data_o); end
        end
        up_data_i = 9'h0AA; put_ev_i = 1'b1; tick(); put_ev_i = 1'b0;
        checks++; if (ovf_o !== 1'b1 || tp.put_data_o !== 9'h155)
            begin failures++; $display("FAIL put_overrun: got %b/%h expected 1/155", ovf_o, tp.put_data_o); end
        tp.put_rdy_i = 1'b1; tick(); tp.put_rdy_i = 1'b0;
        checks++; if (tp.put_req_o !== 1'b0)
            begin failures++; $display("FAIL put_accept: got %b expected 0", tp.put_req_o); end
        // Random traffic against a one-entry buffer model.
        do_reset();
        m_ovf = 1'b0;
        for (int i = 0; i < 150; i++) begin
            pev = ($urandom_range(0, 2) == 0);
            prdy = ($urandom_range(0, 2) == 0);
            d = 9'($urandom_range(0, 511));
            put_ev_i = pev; tp.put_rdy_i = prdy; up_data_i = d;
            if (prdy && slot_q.size() > 0) void'(slot_q.pop_front());
            if (pev) begin
                if (slot_q.size() == 0) slot_q.push_back(d);
                else m_ovf = 1'b1;
            end
            tick();
            put_ev_i = 1'b0; tp.put_rdy_i = 1'b0;
            checks++; if (tp.put_req_o !== (slot_q.size() > 0) || ovf_o !== m_ovf ||
                          (slot_q.size() > 0 && tp.put_data_o !== slot_q[0]))
                begin failures++; $display("FAIL put_rand%0d: got req=%b data=%h ovf=%b expected req=%b ovf=%b", i, tp.put_req_o, tp.put_data_o, ovf_o, slot_q.size() > 0, m_ovf); end
        end
    endtask

    task automatic test_reset_mid_fetch();
        int n;
        do_reset();
        up_data_i = 9'h123; put_ev_i = 1'b1;
        pulse_ev(3'b001);
        put_ev_i = 1'b0;
        n = 0;
        while (!tp.get_req_o && n < 20) begin tick(); n++; end
        tp.get_rdy_i = 1'b1; tick(); tp.get_rdy_i = 1'b0;
        tick();
        checks++; if (dbg_state_o !== 2'd2 || freeze_o !== 3'b001)
            begin failures++; $display("FAIL mid_in_wait: got state=%0d freeze=%b expected 2/001", dbg_state_o, freeze_o); end
        rst_i = 1'b1; tp.rsp_valid_i = 1'b1; tp.rsp_data_i = 9'h1FF;
        tick();
        checks++; if (freeze_o !== 3'b000 || rd_valid_o !== 3'b000 || rd_data_o !== '0 || tp.get_req_o !== 1'b0 ||
                      tp.put_req_o !== 1'b0 || tp.put_data_o !== 9'h000 || dbg_state_o !== 2'd0)
            begin failures++; $display("FAIL mid_reset: got freeze=%b rdv=%b rd=%h req=%b put=%b/%h st=%0d expected all 0", freeze_o, rd_valid_o, rd_data_o, tp.get_req_o, tp.put_req_o, tp.put_data_o, dbg_state_o); end
        rst_i = 1'b0; tp.rsp_valid_i = 1'b0;
        tick();
        checks++; if (rd_valid_o !== 3'b000 || tp.get_req_o !== 1'b0 || freeze_o !== 3'b000)
            begin failures++; $display("FAIL mid_after: got rdv=%b req=%b freeze=%b expected 000/0/000", rd_valid_o, tp.get_req_o, freeze_o); end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "tb_cs_trgt_chan_ctrl timed out");
    end

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_watchdog();
        test_overrun();
        test_put();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
